// File: rtl/pdp8_panel_pkg.sv
// Shared definitions for the PDP-8 front-panel sequencer: FSM states,
// button bit positions and status-word layout.
package pdp8_panel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEM     = 2'd1,
        ST_RUNNING = 2'd2
    } panel_state_t;

    localparam int NUM_BTN     = 6;
    localparam int BTN_LOAD    = 0;
    localparam int BTN_DEPOSIT = 1;
    localparam int BTN_EXAMINE = 2;
    localparam int BTN_RUN     = 3;
    localparam int BTN_HALT    = 4;
    localparam int BTN_STEP    = 5;

    localparam int YEL_RUN  = 0;
    localparam int YEL_BUSY = 1;
    localparam int YEL_ERR  = 2;

    // HALT beats everything, otherwise the lowest set bit wins.
    function automatic logic [NUM_BTN-1:0] pick_command(input logic [NUM_BTN-1:0] press);
        if (press[BTN_HALT])
            return NUM_BTN'(1) << BTN_HALT;
        return press & (~press + NUM_BTN'(1));
    endfunction

endpackage

// File: rtl/panel_button_conditioner.sv
// Button synchronizer, rising-edge detector and shared bounce lockout.
// Emits a registered one-cycle press vector.
module panel_button_conditioner
    import pdp8_panel_pkg::*;
#(
    parameter int LOCKOUT = 65536
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_BTN-1:0] buttons,
    output logic [NUM_BTN-1:0] press
);

    localparam int CW = $clog2(LOCKOUT + 1);

    logic [NUM_BTN-1:0] sync1, sync2, prev;
    logic [NUM_BTN-1:0] rise;
    logic [CW-1:0]      lock_cnt;

    assign rise = sync2 & ~prev;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            press    <= '0;
            lock_cnt <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            prev  <= sync2;
            // Edges seen while the lockout runs are dropped, never queued.
            if (lock_cnt == '0 && |rise) begin
                press    <= rise;
                lock_cnt <= CW'(LOCKOUT);
            end else begin
                press <= '0;
                if (lock_cnt != '0)
                    lock_cnt <= lock_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/panel_sequencer.sv
// Front-panel command sequencer: turns accepted button presses into memory
// transfers and CPU run/step control, and drives the panel display words.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for any command
// ST_MEM     | deposit/examine in flight; only HALT is latched
// ST_RUNNING | CPU running; only HALT (or CPU self-halt) leaves
module panel_sequencer
    import pdp8_panel_pkg::*;
#(
    parameter int LOCKOUT = 65536,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [11:0] switches,
    input  logic [5:0]  buttons,
    output logic        MREQ,
    output logic        MWE,
    output logic [11:0] MADDR,
    output logic [11:0] MWDATA,
    input  logic [11:0] MRDATA,
    input  logic        MACK,
    output logic        RUN,
    output logic        STEP_PULSE,
    input  logic        CPU_HALTED,
    output logic [11:0] green,
    output logic [11:0] red,
    output logic [11:0] yellow
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    panel_state_t state_q, state_d;
    logic [5:0]   press, cmd;
    logic [11:0]  sw1, sw2;
    logic [11:0]  pa_q, pa_d, pd_q, pd_d;
    logic [11:0]  maddr_q, maddr_d, mwdata_q, mwdata_d;
    logic         mreq_q, mreq_d, mwe_q, mwe_d;
    logic         run_q, run_d, step_q, step_d;
    logic         err_q, err_d, halt_pend_q, halt_pend_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    panel_button_conditioner #(.LOCKOUT(LOCKOUT)) u_cond (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .buttons (buttons),
        .press   (press)
    );

    assign cmd = pick_command(press);

    always_comb begin
        state_d     = state_q;
        pa_d        = pa_q;
        pd_d        = pd_q;
        maddr_d     = maddr_q;
        mwdata_d    = mwdata_q;
        mreq_d      = mreq_q;
        mwe_d       = mwe_q;
        run_d       = run_q;
        step_d      = 1'b0;
        err_d       = err_q;
        halt_pend_d = halt_pend_q;
        tcnt_d      = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                halt_pend_d = 1'b0;
                if (halt_pend_q)
                    run_d = 1'b0;
                if (|cmd)
                    err_d = 1'b0;
                if (cmd[BTN_LOAD]) begin
                    pa_d = sw2;
                end else if (cmd[BTN_DEPOSIT]) begin
                    mreq_d   = 1'b1;
                    mwe_d    = 1'b1;
                    maddr_d  = pa_q;
                    mwdata_d = sw2;
                    pd_d     = sw2;
                    tcnt_d   = TW'(TIMEOUT - 1);
                    state_d  = ST_MEM;
                end else if (cmd[BTN_EXAMINE]) begin
                    mreq_d  = 1'b1;
                    mwe_d   = 1'b0;
                    maddr_d = pa_q;
                    tcnt_d  = TW'(TIMEOUT - 1);
                    state_d = ST_MEM;
                end else if (cmd[BTN_RUN]) begin
                    run_d   = 1'b1;
                    state_d = ST_RUNNING;
                end else if (cmd[BTN_STEP]) begin
                    step_d = 1'b1;
                end
            end
            ST_MEM: begin
                if (press[BTN_HALT])
                    halt_pend_d = 1'b1;
                if (MACK) begin
                    if (!mwe_q)
                        pd_d = MRDATA;
                    pa_d    = pa_q + 12'd1;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (tcnt_q == '0) begin
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            ST_RUNNING: begin
                if (cmd[BTN_HALT] || CPU_HALTED) begin
                    run_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            sw1         <= '0;
            sw2         <= '0;
            pa_q        <= '0;
            pd_q        <= '0;
            maddr_q     <= '0;
            mwdata_q    <= '0;
            mreq_q      <= 1'b0;
            mwe_q       <= 1'b0;
            run_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            sw1         <= switches;
            sw2         <= sw1;
            pa_q        <= pa_d;
            pd_q        <= pd_d;
            maddr_q     <= maddr_d;
            mwdata_q    <= mwdata_d;
            mreq_q      <= mreq_d;
            mwe_q       <= mwe_d;
            run_q       <= run_d;
            step_q      <= step_d;
            err_q       <= err_d;
            halt_pend_q <= halt_pend_d;
            tcnt_q      <= tcnt_d;
        end
    end

    always_comb begin
        yellow           = '0;
        yellow[YEL_RUN]  = run_q;
        yellow[YEL_BUSY] = mreq_q;
        yellow[YEL_ERR]  = err_q;
    end

    assign MREQ       = mreq_q;
    assign MWE        = mwe_q;
    assign MADDR      = maddr_q;
    assign MWDATA     = mwdata_q;
    assign RUN        = run_q;
    assign STEP_PULSE = step_q;
    assign green      = pa_q;
    assign red        = pd_q;

endmodule

// File: tb/tb_panel_sequencer.sv
// Bench for panel_sequencer: memory responder plus a panel-level model
// (PA/PD/memory/error/run) driven by directed and randomized button presses.
module tb_panel_sequencer;

    localparam int LOCK = 16;
    localparam int TMO  = 20;
    localparam logic [5:0] B_LOAD = 6'b000001, B_DEP  = 6'b000010, B_EXA  = 6'b000100,
                           B_RUN  = 6'b001000, B_HALT = 6'b010000, B_STEP = 6'b100000;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [11:0] switches;
    logic [5:0]  buttons;
    logic        MREQ, MWE, RUN, STEP_PULSE, MACK;
    logic [11:0] MADDR, MWDATA, MRDATA, green, red, yellow;
    logic        CPU_HALTED;

    logic        mack_force = 1'b0, resp_mack = 1'b0, resp_en = 1'b0;
    logic [11:0] mrdata_force = '0, resp_data = '0;
    assign MACK   = mack_force | resp_mack;
    assign MRDATA = resp_en ? resp_data : mrdata_force;

    always #5 CLK = ~CLK;

    panel_sequencer #(.LOCKOUT(LOCK), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .switches(switches), .buttons(buttons),
        .MREQ(MREQ), .MWE(MWE), .MADDR(MADDR), .MWDATA(MWDATA), .MRDATA(MRDATA),
        .MACK(MACK), .RUN(RUN), .STEP_PULSE(STEP_PULSE), .CPU_HALTED(CPU_HALTED),
        .green(green), .red(red), .yellow(yellow)
    );

    int checks = 0, errors = 0;

    function automatic logic [11:0] mem_init(input int a);
        return 12'((a * 1103) ^ 2730);
    endfunction

    // Memory responder: acks after ack_delay wait cycles, records the request.
    logic [11:0] ram [4096];
    int ack_delay = 0, wait_cnt = 0, mreq_cycles = 0, unstable = 0;
    int xfer_starts = 0, mreq_after_ack = 0, step_count = 0;
    logic in_xfer = 1'b0, ack_we, first_we;
    logic [11:0] ack_addr, ack_wdata, first_addr, first_wdata;

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = mem_init(a);
        forever begin
            @(negedge CLK);
            if (STEP_PULSE) step_count++;
            if (resp_mack) begin
                resp_mack = 1'b0;
                if (MREQ) mreq_after_ack++;
            end else if (MREQ) begin
                if (!in_xfer) begin
                    in_xfer = 1'b1; xfer_starts++; mreq_cycles = 0; wait_cnt = 0;
                    first_addr = MADDR; first_wdata = MWDATA; first_we = MWE;
                end else if (MADDR !== first_addr || MWE !== first_we || MWDATA !== first_wdata) begin
                    unstable++;
                end
                mreq_cycles++;
                if (resp_en) begin
                    if (wait_cnt >= ack_delay) begin
                        ack_addr = MADDR; ack_wdata = MWDATA; ack_we = MWE;
                        if (MWE) ram[MADDR] = MWDATA;
                        resp_data = MWE ? 12'h000 : ram[MADDR];
                        resp_mack = 1'b1;
                        in_xfer   = 1'b0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                in_xfer = 1'b0;
            end
        end
    end

    // Panel-level reference model
    logic [11:0] model_mem [4096];
    logic [11:0] m_pa = '0, m_pd = '0;
    logic        m_err = 1'b0, m_run = 1'b0;

    function automatic logic [11:0] exp_yellow();
        return {9'b0, m_err, 1'b0, m_run};
    endfunction

    task automatic press(input logic [5:0] mask, input logic [11:0] sw);
        @(negedge CLK);
        switches = sw;
        buttons  = mask;
        repeat (3) @(negedge CLK);
        buttons = '0;
        repeat (LOCK + 6) @(negedge CLK);
    endtask

    task automatic check_panel(input string name);
        checks++;
        if (green !== m_pa || red !== m_pd || yellow !== exp_yellow()) begin
            errors++;
            $display("FAIL %s: green=%o red=%o yellow=%o, required green=%o red=%o yellow=%o",
                     name, green, red, yellow, m_pa, m_pd, exp_yellow());
        end
    endtask

    task automatic model_cmd(input logic [5:0] mask, input logic [11:0] sw);
        m_err = 1'b0;
        if (mask == B_LOAD) m_pa = sw;
        else if (mask == B_DEP) begin model_mem[m_pa] = sw; m_pd = sw; m_pa = m_pa + 12'd1; end
        else if (mask == B_EXA) begin m_pd = model_mem[m_pa]; m_pa = m_pa + 12'd1; end
    endtask

    task automatic do_cmd(input logic [5:0] mask, input logic [11:0] sw);
        press(mask, sw);
        model_cmd(mask, sw);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; switches = '1; buttons = '1; mack_force = 1'b1;
        mrdata_force = '1; CPU_HALTED = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({MREQ, MWE, MADDR, MWDATA, RUN, STEP_PULSE, green, red, yellow} !== '0) begin
            errors++;
            $display("FAIL reset_during: outputs=%h required 0",
                     {MREQ, MWE, MADDR, MWDATA, RUN, STEP_PULSE, green, red, yellow});
        end
        RESET_N = 1'b1;
        repeat (8) @(negedge CLK);
        checks++;
        if ({MREQ, MWE, MADDR, MWDATA, RUN, STEP_PULSE, green, red, yellow} !== '0) begin
            errors++;
            $display("FAIL reset_after: outputs=%h required 0",
                     {MREQ, MWE, MADDR, MWDATA, RUN, STEP_PULSE, green, red, yellow});
        end
        switches = '0; buttons = '0; mack_force = 1'b0; mrdata_force = '0; CPU_HALTED = 1'b0;
        repeat (LOCK + 6) @(negedge CLK);
    endtask

    task automatic test_deposit();
        resp_en = 1'b1; ack_delay = 3;
        do_cmd(B_LOAD, 12'o0200);
        do_cmd(B_DEP, 12'o7402);
        checks++;
        if (ack_addr !== 12'o0200 || ack_wdata !== 12'o7402 || ack_we !== 1'b1) begin
            errors++;
            $display("FAIL deposit_bus: addr=%o data=%o we=%b required 0200 7402 1", ack_addr, ack_wdata, ack_we);
        end
        check_panel("deposit_panel");
    endtask

    task automatic test_examine_wrap();
        ack_delay = 0;
        do_cmd(B_LOAD, 12'o7777);
        do_cmd(B_DEP, 12'o1234);
        do_cmd(B_LOAD, 12'o7777);
        do_cmd(B_EXA, 12'o0000);
        checks++;
        if (red !== 12'o1234 || green !== 12'o0000) begin
            errors++;
            $display("FAIL examine_wrap: red=%o green=%o required 1234 0000", red, green);
        end
        check_panel("examine_panel");
    endtask

    task automatic test_bounce();
        logic [11:0] vals [5];
        for (int i = 0; i < 5; i++) vals[i] = 12'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            switches = vals[i]; buttons = B_LOAD;
            @(negedge CLK);
            buttons = '0;
            @(negedge CLK);
        end
        repeat (LOCK + 6) @(negedge CLK);
        model_cmd(B_LOAD, vals[0]);
        check_panel("bounce_first_only");
        do_cmd(B_LOAD, vals[4] ^ 12'o5555);
        check_panel("bounce_after_lockout");
    endtask

    task automatic test_timeout();
        int n;
        resp_en = 1'b0;
        @(negedge CLK);
        buttons = B_EXA;
        n = 0;
        while (!MREQ && n < 10) begin @(negedge CLK); n++; end
        checks++;
        if (!MREQ || yellow[1] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy: mreq=%b yellow1=%b required 1 1", MREQ, yellow[1]);
        end
        buttons = '0;
        n = 0;
        while (MREQ && n < 100) begin @(negedge CLK); n++; end
        checks++;
        if (MREQ || mreq_cycles != TMO) begin
            errors++;
            $display("FAIL timeout_len: mreq=%b cycles=%0d required 0 %0d", MREQ, mreq_cycles, TMO);
        end
        m_err = 1'b1;
        check_panel("timeout_err");
        repeat (LOCK + 6) @(negedge CLK);
        resp_en = 1'b1;
        do_cmd(B_LOAD, 12'o0017);
        check_panel("timeout_clear");
    endtask

    task automatic test_reset_mid();
        int n;
        resp_en = 1'b0;
        @(negedge CLK);
        buttons = B_DEP;
        n = 0;
        while (!MREQ && n < 10) begin @(negedge CLK); n++; end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (MREQ !== 1'b0 || green !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: mreq=%b green=%o required 0 0", MREQ, green);
        end
        buttons = '0;
        @(negedge CLK);
        RESET_N = 1'b1;
        m_pa = '0; m_pd = '0; m_err = 1'b0; m_run = 1'b0;
        repeat (4) @(negedge CLK);
        resp_en = 1'b1;
    endtask

    task automatic test_run_control();
        int x0;
        logic [11:0] red0;
        press(B_RUN, 12'o0000);
        m_run = 1'b1; m_err = 1'b0;
        check_panel("run_on");
        x0 = xfer_starts; red0 = red;
        press(B_DEP, 12'o4444);
        checks++;
        if (xfer_starts != x0 || red !== red0 || RUN !== 1'b1) begin
            errors++;
            $display("FAIL run_ignores_dep: xfers=%0d red=%o run=%b required %0d %o 1",
                     xfer_starts - x0, red, RUN, 0, red0);
        end
        press(B_HALT | B_RUN, 12'o0000);
        m_run = 1'b0;
        check_panel("halt_priority");
        press(B_RUN, 12'o0000);
        checks++;
        if (RUN !== 1'b1) begin
            errors++;
            $display("FAIL rerun: run=%b required 1", RUN);
        end
        @(negedge CLK); CPU_HALTED = 1'b1;
        @(negedge CLK); CPU_HALTED = 1'b0;
        repeat (3) @(negedge CLK);
        check_panel("cpu_halted");
    endtask

    task automatic test_step();
        int s0;
        s0 = step_count;
        @(negedge CLK);
        buttons = B_STEP;
        @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (STEP_PULSE !== 1'b0) begin
            errors++;
            $display("FAIL step_early: step=%b required 0 at k+2", STEP_PULSE);
        end
        @(posedge CLK); #1;
        checks++;
        if (STEP_PULSE !== 1'b1) begin
            errors++;
            $display("FAIL step_latency: step=%b required 1 at k+3", STEP_PULSE);
        end
        @(posedge CLK); #1;
        buttons = '0;
        repeat (LOCK + 6) @(negedge CLK);
        checks++;
        if (step_count - s0 != 1) begin
            errors++;
            $display("FAIL step_count: pulses=%0d required 1", step_count - s0);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [4];
        logic [5:0]  op;
        logic [11:0] sw;
        int s0;
        ops[0] = B_LOAD; ops[1] = B_DEP; ops[2] = B_EXA; ops[3] = B_STEP;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 3)];
            sw = 12'($urandom);
            ack_delay = $urandom_range(0, 5);
            s0 = step_count;
            do_cmd(op, sw);
            check_panel("random_op");
            if (op == B_STEP) begin
                checks++;
                if (step_count - s0 != 1) begin
                    errors++;
                    $display("FAIL random_step: pulses=%0d required 1", step_count - s0);
                end
            end
        end
        checks++;
        if (unstable != 0 || mreq_after_ack != 0) begin
            errors++;
            $display("FAIL bus_stable: unstable=%0d mreq_after_ack=%0d required 0 0", unstable, mreq_after_ack);
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) model_mem[a] = mem_init(a);
        test_reset();
        test_deposit();
        test_examine_wrap();
        test_bounce();
        test_timeout();
        test_reset_mid();
        test_run_control();
        test_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
